// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for the five-stage miniRV core.
//
// Keeps a shadow scoreboard of the destination registers in flight in the
// EX, MEM and WB stages. From it, and from the instruction currently in ID,
// it derives operand-forwarding selects, load-use stalls and control-hazard
// flushes. Two wrapping counters record stall cycles and redirect events.
//
// Ports
//   cpu_clk, cpu_rst        clock, synchronous active-high reset
//   id_valid                ID holds a real instruction (not a bubble)
//   id_rs1, id_rs2          ID source registers
//   id_use_rs1, id_use_rs2  ID instruction actually reads rs1 / rs2
//   id_rd, id_rf_we         ID destination register and its write enable
//   id_is_load              ID instruction is a load
//   ex_redirect             EX resolved a taken branch / jal / jalr
//   pc_hold, if_id_hold     freeze PC and IF_ID (load-use stall)
//   id_ex_bubble            load NOP into ID_EX (load-use stall)
//   if_id_flush, id_ex_flush  kill the two wrong-path instructions
//   fwd_a, fwd_b            operand source: 0 regfile, 1 EX, 2 MEM, 3 WB
//   stall_cnt, flush_cnt    event counters, wrap modulo 2^CNT_W

// Per-source forwarding / load-use detection. One instance per operand.
//   rs, en                  source register and "operand is read"
//   ex_*, mem_*, wb_*       scoreboard entry relevance and destination
//   sel                     forwarding select for this operand
//   load_hit                operand depends on a load still in EX
module hazard_src (
  input  logic [4:0] rs,
  input  logic       en,
  input  logic       ex_rel,
  input  logic       ex_load,
  input  logic [4:0] ex_rd,
  input  logic       mem_rel,
  input  logic [4:0] mem_rd,
  input  logic       wb_rel,
  input  logic [4:0] wb_rd,
  output logic [1:0] sel,
  output logic       load_hit
);
  logic active;
  logic ex_hit, mem_hit, wb_hit;

  // x0 is hard-wired zero: never a dependency.
  assign active  = en && (rs != 5'd0);
  assign ex_hit  = active && ex_rel  && (ex_rd  == rs);
  assign mem_hit = active && mem_rel && (mem_rd == rs);
  assign wb_hit  = active && wb_rel  && (wb_rd  == rs);

  // A load in EX has no data yet; fall through to older stages so the
  // select is still well-defined (the stall makes it don't-care anyway).
  assign load_hit = ex_hit && ex_load;

  always_comb begin
    sel = 2'd0;
    if (ex_hit && !ex_load) sel = 2'd1;
    else if (mem_hit)       sel = 2'd2;
    else if (wb_hit)        sel = 2'd3;
  end
endmodule

module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_rf_we,
  input  logic             id_is_load,
  input  logic             ex_redirect,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       load;
  } sb_ent_t;

  localparam int EX  = 0;
  localparam int MEM = 1;
  localparam int WB  = 2;

  sb_ent_t [2:0] sb;
  logic    [2:0] rel;

  logic [1:0][4:0] src_rs;
  logic [1:0]      src_en;
  logic [1:0][1:0] src_sel;
  logic [1:0]      src_load_hit;

  logic load_use;
  logic stall;

  // An entry matters only if it will really write a nonzero register.
  for (genvar s = 0; s < 3; s++) begin : g_rel
    assign rel[s] = sb[s].valid && sb[s].we && (sb[s].rd != 5'd0);
  end

  assign src_rs = {id_rs2, id_rs1};
  assign src_en = {id_use_rs2, id_use_rs1};

  for (genvar s = 0; s < 2; s++) begin : g_src
    hazard_src u_src (
      .rs       (src_rs[s]),
      .en       (src_en[s]),
      .ex_rel   (rel[EX]),
      .ex_load  (sb[EX].load),
      .ex_rd    (sb[EX].rd),
      .mem_rel  (rel[MEM]),
      .mem_rd   (sb[MEM].rd),
      .wb_rel   (rel[WB]),
      .wb_rd    (sb[WB].rd),
      .sel      (src_sel[s]),
      .load_hit (src_load_hit[s])
    );
  end

  assign fwd_a = src_sel[0];
  assign fwd_b = src_sel[1];

  // Redirect wins: the ID instruction is wrong-path and gets flushed, so
  // stalling for it would only waste a cycle and delay the PC taking npc.
  assign load_use = id_valid && (|src_load_hit);
  assign stall    = load_use && !ex_redirect;

  assign pc_hold      = stall;
  assign if_id_hold   = stall;
  assign id_ex_bubble = stall;
  assign if_id_flush  = ex_redirect;
  assign id_ex_flush  = ex_redirect;

  // The load flag is only consulted in EX; older copies ride along so the
  // entries stay uniform.
  logic unused_load;
  assign unused_load = sb[MEM].load ^ sb[WB].load;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      sb        <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      sb[WB]  <= sb[MEM];
      sb[MEM] <= sb[EX];
      // A stalled or flushed ID instruction does not advance; EX gets a
      // bubble, which also guarantees a stall never lasts past one cycle.
      if (stall || ex_redirect) sb[EX] <= '0;
      else sb[EX] <= '{valid: id_valid, rd: id_rd, we: id_rf_we, load: id_is_load};
      if (stall)       stall_cnt <= stall_cnt + CNT_W'(1);
      if (ex_redirect) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage miniRV core (IF, ID, EX, MEM, WB). It keeps a shadow scoreboard of in-flight destination registers in the EX, MEM and WB stages. From that scoreboard it produces operand-forwarding selects, load-use stalls and control-hazard flushes for the PC, IF_ID and ID_EX pipeline registers. Two free-running counters record stall and flush events for bring-up.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush event counters

Ports:
- cpu_clk  in  1  core clock
- cpu_rst  in  1  reset, synchronous, active-high
- id_valid  in  1  ID stage holds a real instruction (not a bubble)
- id_rs1  in  5  ID source register 1 (inst[19:15])
- id_rs2  in  5  ID source register 2 (inst[24:20])
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- id_rd  in  5  ID destination register (inst[11:7])
- id_rf_we  in  1  ID instruction writes the register file
- id_is_load  in  1  ID instruction is a load (rf_wsel selects DRAM data)
- ex_redirect  in  1  EX resolved a taken branch, jal or jalr (npc is not pc+4)
- pc_hold  out  1  freeze PC
- if_id_hold  out  1  freeze IF_ID
- id_ex_bubble  out  1  load NOP into ID_EX (clear rf_we and dram_we)
- if_id_flush  out  1  clear IF_ID to NOP
- id_ex_flush  out  1  clear ID_EX to NOP
- fwd_a  out  2  rs1 operand source: 0 = regfile, 1 = EX alu_c, 2 = MEM write-back value, 3 = WB wD
- fwd_b  out  2  rs2 operand source, same encoding as fwd_a
- stall_cnt  out  CNT_W  number of load-use stall cycles
- flush_cnt  out  CNT_W  number of redirect flush events

## Operation
- Scoreboard: three entries, EX, MEM and WB. Each entry holds {valid, rd, we, load}. An entry is hazard-relevant only if valid && we && rd != 0.
- Advance on every cpu_clk edge:
  - WB takes MEM.
  - MEM takes EX.
  - EX takes ID info ({id_valid, id_rd, id_rf_we, id_is_load}), unless a stall or flush is active; in that case EX becomes invalid.
- Forwarding, evaluated for each source independently, only if id_use_rsX && rsX != 0. First match wins:
  - EX match and EX not a load: select 1.
  - MEM match: select 2.
  - WB match: select 3.
  - Otherwise: select 0.
  - The youngest producer always wins.
- Load-use stall: asserted when id_valid, the EX entry is relevant with load = 1, and its rd equals a used, nonzero rs1 or rs2.
  - On stall: pc_hold = if_id_hold = id_ex_bubble = 1.
  - On stall: fwd_a and fwd_b for the offending operand are don't-care.
  - On the next cycle the load sits in MEM and forwarding selects 2.
- Redirect: when ex_redirect = 1, if_id_flush = id_ex_flush = 1. Both wrong-path instructions (in IF and ID) are killed.
- Priority: redirect beats stall. When both are true:
  - Flush only: pc_hold, if_id_hold and id_ex_bubble = 0.
  - No stall is counted.
  - The PC takes npc.
- Counters:
  - stall_cnt increments once per stall cycle.
  - flush_cnt increments once per redirect cycle.
  - Both wrap modulo 2^CNT_W.

## Timing
- All control outputs (hold, bubble, flush, fwd) are combinational from the ID inputs and the registered scoreboard. No added latency.
- Scoreboard and counters are registered and update on the cpu_clk rising edge.
- Load-use costs exactly 1 stall cycle. A redirect costs exactly 2 bubbles.
- Back-to-back loads, each used by the next instruction: each pair stalls 1 cycle. A stall can never persist beyond 1 cycle for the same instruction.
- Reset (cpu_rst = 1 at an edge):
  - All scoreboard entries become invalid.
  - stall_cnt = flush_cnt = 0.
  - While the scoreboard is empty, every control output is 0.
  - Reset mid-stall cancels the stall on the next cycle.
- Register x0 never causes forwarding or a stall, including when id_rd = 0 on a load.
- id_valid = 0 in ID: no stall is generated, and a bubble enters EX.

## Test plan
- Forwarding from EX: addi x5,x0,7 then add x6,x5,x5 → when add is in ID, fwd_a = fwd_b = 1, no stall, stall_cnt stays 0.
- Load-use: lw x7,0(x1) then addi x8,x7,1 → exactly 1 cycle with pc_hold = if_id_hold = id_ex_bubble = 1; next cycle fwd_a = 2, stall_cnt = 1.
- Distance 3 and x0: addi x9,…; nop; nop; sub x10,x9,x0 → fwd_a = 3, fwd_b = 0. Separately, lw x0,0(x1); add x2,x0,x0 → no stall.
- Redirect plus stall collision: assert ex_redirect in the same cycle as a load-use condition → flushes = 1, holds = 0, flush_cnt += 1, stall_cnt unchanged.
- Priority: x3 written at EX, MEM and WB simultaneously, with ID reading x3 → fwd = 1. Then with the EX producer as a load → stall, and afterwards fwd = 2.
- Reset: pulse cpu_rst during a stall cycle → the next cycle has all outputs 0 and both counters 0. Drive 70000 redirect cycles → flush_cnt wraps to 70000 - 65536 = 4464.
